// File: rtl/cla_pkg.sv
// Shared constants, types and the second-level lookahead equations for the
// 16-bit carry-lookahead add/subtract/compare unit.
package cla_pkg;

   localparam int WIDTH   = 16;
   localparam int GROUP   = 4;
   localparam int NGROUPS = WIDTH / GROUP;

   typedef logic signed [WIDTH-1:0] word_t;

   // Returns {c16, c12, c8, c4}; every carry is a flat sum of products of the
   // group G/P terms, so no carry ripples from one group to the next.
   function automatic logic [NGROUPS-1:0] group_carries(
      input logic [NGROUPS-1:0] g,
      input logic [NGROUPS-1:0] p,
      input logic               c0
   );
      logic [NGROUPS-1:0] c;
      c[0] = g[0] | (p[0] & c0);
      c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & c0);
      c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c0);
      return c;
   endfunction

endpackage

// File: rtl/cla4_group.sv
// 4-bit carry-lookahead group: sum bits from a local carry-in plus the
// group generate/propagate terms consumed by the second-level unit.
module cla4_group
   import cla_pkg::*;
(
   input  logic [GROUP-1:0] a_i,
   input  logic [GROUP-1:0] b_i,
   input  logic             c_i,
   output logic [GROUP-1:0] sum_o,
   output logic             gg_o,
   output logic             gp_o
);

   logic [GROUP-1:0] g;
   logic [GROUP-1:0] p;
   logic [GROUP-1:0] c;

   assign g = a_i & b_i;
   assign p = a_i ^ b_i;

   assign c[0] = c_i;
   assign c[1] = g[0] | (p[0] & c_i);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & c_i);

   assign sum_o = p ^ c;
   assign gg_o  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]);
   assign gp_o  = &p;

endmodule

// File: rtl/cla16_addsub_cmp.sv
// Registered 16-bit signed add, subtract, overflow and less-than, built from
// two independent two-level carry-lookahead adders.
module cla16_addsub_cmp
   import cla_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] diff,
   output logic             of_s,
   output logic             of_d,
   output logic             less_than
);

   logic [WIDTH-1:0]   b_n;
   logic [NGROUPS-1:0] add_gg, add_gp, sub_gg, sub_gp;
   // Index k is the carry into group k; index NGROUPS is the carry out of bit 15.
   logic [NGROUPS:0]   add_c, sub_c;
   word_t              add_s, sub_s;

   word_t sum_d, sum_q, diff_d, diff_q;
   logic  of_s_d, of_s_q, of_d_d, of_d_q, lt_d, lt_q;
   logic  add_c15, sub_c15;

   assign b_n = ~b;

   assign add_c[0]         = 1'b0;
   assign add_c[NGROUPS:1] = group_carries(add_gg, add_gp, add_c[0]);
   assign sub_c[0]         = 1'b1;
   assign sub_c[NGROUPS:1] = group_carries(sub_gg, sub_gp, sub_c[0]);

   for (genvar gi = 0; gi < NGROUPS; gi++) begin : g_grp
      cla4_group u_add (
         .a_i   (a[gi*GROUP +: GROUP]),
         .b_i   (b[gi*GROUP +: GROUP]),
         .c_i   (add_c[gi]),
         .sum_o (add_s[gi*GROUP +: GROUP]),
         .gg_o  (add_gg[gi]),
         .gp_o  (add_gp[gi])
      );
      cla4_group u_sub (
         .a_i   (a[gi*GROUP +: GROUP]),
         .b_i   (b_n[gi*GROUP +: GROUP]),
         .c_i   (sub_c[gi]),
         .sum_o (sub_s[gi*GROUP +: GROUP]),
         .gg_o  (sub_gg[gi]),
         .gp_o  (sub_gp[gi])
      );
   end

   // Carry into the sign bit recovered from its sum bit: s15 = a15 ^ b15 ^ c15.
   assign add_c15 = a[WIDTH-1] ^ b[WIDTH-1]   ^ add_s[WIDTH-1];
   assign sub_c15 = a[WIDTH-1] ^ b_n[WIDTH-1] ^ sub_s[WIDTH-1];

   always_comb begin
      sum_d  = add_s;
      diff_d = sub_s;
      of_s_d = add_c15 ^ add_c[NGROUPS];
      of_d_d = sub_c15 ^ sub_c[NGROUPS];
      lt_d   = sub_s[WIDTH-1] ^ of_d_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sum_q  <= '0;
         diff_q <= '0;
         of_s_q <= 1'b0;
         of_d_q <= 1'b0;
         lt_q   <= 1'b0;
      end else begin
         sum_q  <= sum_d;
         diff_q <= diff_d;
         of_s_q <= of_s_d;
         of_d_q <= of_d_d;
         lt_q   <= lt_d;
      end
   end

   assign sum       = sum_q;
   assign diff      = diff_q;
   assign of_s      = of_s_q;
   assign of_d      = of_d_q;
   assign less_than = lt_q;

endmodule

// File: tb/tb_cla16_addsub_cmp.sv
// Self-checking bench for cla16_addsub_cmp: directed boundary vectors, reset
// behaviour and randomized back-to-back operands against an integer model.
module tb_cla16_addsub_cmp;

   typedef struct packed {
      logic [15:0] sum;
      logic [15:0] diff;
      logic        of_s;
      logic        of_d;
      logic        lt;
   } res_t;

   localparam int RES_W = $bits(res_t);

   logic        clk;
   logic        reset;
   logic [15:0] a;
   logic [15:0] b;
   logic [15:0] sum;
   logic [15:0] diff;
   logic        of_s;
   logic        of_d;
   logic        less_than;

   logic [RES_W-1:0] exp_q[$];
   int tests_run    = 0;
   int tests_failed = 0;

   cla16_addsub_cmp dut (
      .clk       (clk),
      .reset     (reset),
      .a         (a),
      .b         (b),
      .sum       (sum),
      .diff      (diff),
      .of_s      (of_s),
      .of_d      (of_d),
      .less_than (less_than)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- reference model ----------------
   function automatic res_t model(input logic [15:0] ma, input logic [15:0] mb);
      res_t r;
      int sa, sb, s, d;
      sa = int'($signed(ma));
      sb = int'($signed(mb));
      s  = sa + sb;
      d  = sa - sb;
      r.sum  = s[15:0];
      r.diff = d[15:0];
      r.of_s = (s > 32767) || (s < -32768);
      r.of_d = (d > 32767) || (d < -32768);
      r.lt   = (sa < sb);
      return r;
   endfunction

   // ---------------- scoreboard ----------------
   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      res_t e;
      if (exp_q.size() == 0) begin
         tests_run++;
         tests_failed++;
         $error("FAIL %s: observed empty expected queue, required one entry", tag);
      end else begin
         e = res_t'(exp_q.pop_front());
         check({tag, ".sum"},  sum,                e.sum);
         check({tag, ".diff"}, diff,               e.diff);
         check({tag, ".of_s"}, {15'd0, of_s},      {15'd0, e.of_s});
         check({tag, ".of_d"}, {15'd0, of_d},      {15'd0, e.of_d});
         check({tag, ".lt"},   {15'd0, less_than}, {15'd0, e.lt});
      end
   endtask

   // ---------------- driver tasks ----------------
   // Drive operands away from the edge, let one edge capture them, then check.
   task automatic apply(input string tag, input logic [15:0] va, input logic [15:0] vb,
                        input logic rst);
      @(negedge clk);
      a     = va;
      b     = vb;
      reset = rst;
      exp_q.push_back(rst ? RES_W'(0) : RES_W'(model(va, vb)));
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   task automatic apply_fixed(input string tag, input logic [15:0] va, input logic [15:0] vb,
                              input logic [15:0] esum, input logic eofs,
                              input logic [15:0] ediff, input logic eofd, input logic elt);
      res_t e;
      @(negedge clk);
      a     = va;
      b     = vb;
      reset = 1'b0;
      e.sum = esum; e.of_s = eofs; e.diff = ediff; e.of_d = eofd; e.lt = elt;
      exp_q.push_back(RES_W'(e));
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [15:0] ra, rb;
      reset = 1'b1;
      a     = 16'h1234;
      b     = 16'h4321;

      // Reset state, with nonzero operands present.
      apply("reset0", 16'h1234, 16'h4321, 1'b1);
      apply("reset1", 16'h7FFF, 16'h8000, 1'b1);

      // Directed vectors with hand-computed expectations.
      apply_fixed("tp1",  16'h7FFF, 16'hFFFF, 16'h7FFE, 1'b0, 16'h8000, 1'b1, 1'b0);
      apply_fixed("tp2",  16'hFFEC, 16'h0028, 16'h0014, 1'b0, 16'hFFC4, 1'b0, 1'b1);
      apply_fixed("tp3",  16'h0BB8, 16'h07D0, 16'h1388, 1'b0, 16'h03E8, 1'b0, 1'b0);
      apply_fixed("tp4",  16'h8300, 16'h8AD0, 16'h0DD0, 1'b1, 16'hF830, 1'b0, 1'b1);
      apply_fixed("tp5a", 16'h89AB, 16'h1682, 16'hA02D, 1'b0, 16'h7329, 1'b1, 1'b1);
      apply_fixed("tp5b", 16'h1888, 16'h7D01, 16'h9589, 1'b1, 16'h9B87, 1'b0, 1'b1);
      apply_fixed("bnd_min_minus1", 16'h8000, 16'h0001, 16'h8001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
      apply_fixed("bnd_min_min",    16'h8000, 16'h8000, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0);
      apply_fixed("bnd_equal",      16'h5A5A, 16'h5A5A, 16'hB4B4, 1'b1, 16'h0000, 1'b0, 1'b0);
      apply_fixed("ripple_full",    16'hFFFF, 16'h0001, 16'h0000, 1'b0, 16'hFFFE, 1'b0, 1'b1);
      apply_fixed("ripple_pos",     16'h0FFF, 16'h0001, 16'h1000, 1'b0, 16'h0FFE, 1'b0, 1'b0);

      // Reset asserted mid-stream, then the first result after release.
      apply_fixed("tp6_pre", 16'hFFC4, 16'hFCE0, 16'hFCA4, 1'b0, 16'h02E4, 1'b0, 1'b0);
      apply("tp6_reset", 16'h7FFF, 16'h0001, 1'b1);
      apply("tp6_post",  16'h7FFF, 16'h0001, 1'b0);

      // Randomized back-to-back operands.
      for (int i = 0; i < 10000; i++) begin
         ra = 16'($urandom_range(0, 65535));
         case ($urandom_range(0, 7))
            0:       rb = ra;
            1:       rb = ~ra + 16'd1;
            2:       rb = {ra[15], 15'($urandom_range(0, 32767))};
            default: rb = 16'($urandom_range(0, 65535));
         endcase
         apply("rand", ra, rb, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
